// File: rtl/sha2_multiblock_core.sv
// ---------------------------------------------------------------------------
// sha2_multiblock_core
//
// Iterative SHA-256 / SHA-224 compression core. It processes one 512-bit
// pre-padded block at a time and chains across blocks to hash multi-block
// messages. UNROLL rounds (1, 2 or 4) are computed per clock.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   blk_valid    : a padded 512-bit block is offered
//   blk_ready    : core is idle and can take a block
//   blk_data     : block, big-endian (W0 = bits 511:480)
//   blk_first    : block starts a message, chaining state reloads from IV
//   blk_last     : block ends a message, a digest is produced
//   mode_224     : 1 = SHA-224, 0 = SHA-256 (taken with a first block only)
//   digest       : final hash {H0..H7}, low word zeroed in SHA-224 mode
//   digest_valid : one-cycle pulse when digest is updated
//   busy         : block in progress (inverse of blk_ready)
//   round_idx    : index of the next round to execute, 0 while idle
//   state_dbg    : current FSM state (IDLE/ROUND/UPDATE) for observation
// ---------------------------------------------------------------------------
module sha2_multiblock_core #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         mode_224,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy,
    output logic [6:0]   round_idx,
    output logic [1:0]   state_dbg
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("sha2_multiblock_core: UNROLL must be 1, 2 or 4");
    end

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ROUND  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] iv_word(input logic m, input logic [2:0] i);
        return m ? IV224[i] : IV256[i];
    endfunction

    logic [1:0]   state_q, state_d;
    logic [6:0]   round_idx_q, round_idx_d;
    logic [31:0]  h_q [8];
    logic [31:0]  h_d [8];
    logic [31:0]  wv_q [8];     // working variables a..h at index 0..7
    logic [31:0]  wv_d [8];
    logic [31:0]  w_q [16];     // message schedule window, w_q[0] = W[t]
    logic [31:0]  w_d [16];
    logic         mode_q, mode_d;
    logic         last_q, last_d;
    logic [255:0] digest_q, digest_d;
    logic         digest_valid_q, digest_valid_d;

    // Result of UNROLL chained rounds starting from the registered state.
    logic [31:0]  rv [8];
    logic [31:0]  rw [16];
    logic [31:0]  t1, t2, wn;
    logic [5:0]   t;

    always_comb begin
        rv = wv_q;
        rw = w_q;
        t1 = '0;
        t2 = '0;
        wn = '0;
        t  = round_idx_q[5:0];
        for (int j = 0; j < UNROLL; j++) begin
            t  = round_idx_q[5:0] + 6'(j);
            t1 = rv[7] + big_s1(rv[4]) + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6])) + K[t] + rw[0];
            t2 = big_s0(rv[0]) + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
            // Next schedule word W[t+16] from the current window.
            wn = small_s1(rw[14]) + rw[9] + small_s0(rw[1]) + rw[0];
            rv[7] = rv[6];
            rv[6] = rv[5];
            rv[5] = rv[4];
            rv[4] = rv[3] + t1;
            rv[3] = rv[2];
            rv[2] = rv[1];
            rv[1] = rv[0];
            rv[0] = t1 + t2;
            for (int k = 0; k < 15; k++) begin
                rw[k] = rw[k + 1];
            end
            rw[15] = wn;
        end
    end

    // Handshake: a block transfers on a rising edge where blk_valid and
    // blk_ready are both high; blk_ready is high only in IDLE, and the
    // block-side inputs are ignored on every other edge.
    always_comb begin
        state_d        = state_q;
        round_idx_d    = round_idx_q;
        h_d            = h_q;
        wv_d           = wv_q;
        w_d            = w_q;
        mode_d         = mode_q;
        last_d         = last_q;
        digest_d       = digest_q;
        digest_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = blk_data[511 - 32*i -: 32];
                    end
                    for (int i = 0; i < 8; i++) begin
                        wv_d[i] = blk_first ? iv_word(mode_224, 3'(i)) : h_q[i];
                        if (blk_first) begin
                            h_d[i] = iv_word(mode_224, 3'(i));
                        end
                    end
                    if (blk_first) begin
                        mode_d = mode_224;
                    end
                    last_d      = blk_last;
                    round_idx_d = 7'd0;
                    state_d     = S_ROUND;
                end
            end
            S_ROUND: begin
                wv_d        = rv;
                w_d         = rw;
                round_idx_d = round_idx_q + 7'(UNROLL);
                if (round_idx_q == 7'(64 - UNROLL)) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + wv_q[i];
                end
                if (last_q) begin
                    digest_d = mode_q ? {h_d[0], h_d[1], h_d[2], h_d[3], h_d[4], h_d[5], h_d[6], 32'h0}
                                      : {h_d[0], h_d[1], h_d[2], h_d[3], h_d[4], h_d[5], h_d[6], h_d[7]};
                    digest_valid_d = 1'b1;
                end
                round_idx_d = 7'd0;
                state_d     = S_IDLE;
            end
            default: begin
                round_idx_d = 7'd0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            round_idx_q    <= 7'd0;
            mode_q         <= 1'b0;
            last_q         <= 1'b0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= IV256[i];
                wv_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            round_idx_q    <= round_idx_d;
            mode_q         <= mode_d;
            last_q         <= last_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            h_q            <= h_d;
            wv_q           <= wv_d;
            w_q            <= w_d;
        end
    end

    assign blk_ready    = (state_q == S_IDLE);
    assign busy         = ~blk_ready;
    assign round_idx    = round_idx_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_sha2_multiblock_core.sv
// ---------------------------------------------------------------------------
// tb_sha2_multiblock_core
//
// Three cores (UNROLL = 1, 2, 4) share the block-side inputs but each has its
// own blk_valid. A negedge monitor counts accepts and digest pulses and feeds
// the UNROLL=1 digests to a scoreboard keyed on an expected queue.
// ---------------------------------------------------------------------------
module tb_sha2_multiblock_core;

    localparam int W = 256;

    localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK2 = {480'h0, 32'h000001c0};
    localparam logic [255:0] D256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] D2   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]   vld = 3'b000;
    logic [511:0] data = '0;
    logic         first = 1'b0;
    logic         last = 1'b0;
    logic         mode = 1'b0;
    logic [2:0]   rdy, dv, bsy;
    logic [255:0] dig [3];
    logic [6:0]   ridx [3];
    logic [1:0]   st [3];

    sha2_multiblock_core #(.UNROLL(1)) u1 (
        .clk(clk), .rst(rst), .blk_valid(vld[0]), .blk_ready(rdy[0]), .blk_data(data),
        .blk_first(first), .blk_last(last), .mode_224(mode), .digest(dig[0]),
        .digest_valid(dv[0]), .busy(bsy[0]), .round_idx(ridx[0]), .state_dbg(st[0]));
    sha2_multiblock_core #(.UNROLL(2)) u2 (
        .clk(clk), .rst(rst), .blk_valid(vld[1]), .blk_ready(rdy[1]), .blk_data(data),
        .blk_first(first), .blk_last(last), .mode_224(mode), .digest(dig[1]),
        .digest_valid(dv[1]), .busy(bsy[1]), .round_idx(ridx[1]), .state_dbg(st[1]));
    sha2_multiblock_core #(.UNROLL(4)) u4 (
        .clk(clk), .rst(rst), .blk_valid(vld[2]), .blk_ready(rdy[2]), .blk_data(data),
        .blk_first(first), .blk_last(last), .mode_224(mode), .digest(dig[2]),
        .digest_valid(dv[2]), .busy(bsy[2]), .round_idx(ridx[2]), .state_dbg(st[2]));

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] exp_q [$];
    logic [W-1:0] got_q [$];
    int ncyc = 0;
    int acc_cnt [3] = '{0, 0, 0};
    int acc_t   [3] = '{0, 0, 0};
    int acc_tp  [3] = '{0, 0, 0};
    int dv_cnt  [3] = '{0, 0, 0};
    int lat     [3] = '{0, 0, 0};
    logic [2:0] acc_pend = 3'b000;

    // acc_t is the first negedge after an accept edge; lat counts negedges
    // from there to the one where digest_valid is seen.
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (acc_pend[i]) begin
                acc_cnt[i] <= acc_cnt[i] + 1;
                acc_tp[i]  <= acc_t[i];
                acc_t[i]   <= ncyc + 1;
            end
            acc_pend[i] <= vld[i] && rdy[i] && !rst;
            if (dv[i]) begin
                dv_cnt[i] <= dv_cnt[i] + 1;
                lat[i]    <= ncyc + 1 - acc_t[i];
            end
        end
        if (dv[0]) got_q.push_back(dig[0]);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, got no response, expected one within bound", name);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a block to the cores in en; returns just after the accept edge.
    task automatic send(input logic [511:0] d, input logic f, input logic l,
                        input logic m, input logic [2:0] en);
        int n = 0;
        data  = d;
        first = f;
        last  = l;
        mode  = m;
        vld   = en;
        while (((rdy & en) != en) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout_fail("send_accept");
        tick();
        vld = 3'b000;
        for (int k = 0; k < 16; k++) data[32*k +: 32] = $urandom;
        first = 1'($urandom_range(0, 1));
        last  = 1'($urandom_range(0, 1));
        mode  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!rdy[0] && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout_fail(name);
        tick();
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: got no digest_valid, expected digest %h", name, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                check(name, got_q.pop_front(), exp_q.pop_front());
            end
        end
        if (got_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d extra digest_valid pulses, expected 0", name, got_q.size());
            got_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 256'(rdy[0]), 256'd1);
        check({tag, "_busy"}, 256'(bsy[0]), 256'd0);
        check({tag, "_round_idx"}, 256'(ridx[0]), 256'd0);
        check({tag, "_digest_valid"}, 256'(dv[0]), 256'd0);
        check({tag, "_digest"}, dig[0], 256'd0);
        check({tag, "_state"}, 256'(st[0]), 256'd0);
    endtask

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
        logic         mode;
        logic         has_dv;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int acc0, dv0, n;
        int dvs [3];
        logic [255:0] held;

        // Mode on the second block of the chained message must be ignored.
        vecs[0] = '{ABC,  1'b1, 1'b1, 1'b0, 1'b1, D256};
        vecs[1] = '{ABC,  1'b1, 1'b1, 1'b1, 1'b1, D224};
        vecs[2] = '{BLK1, 1'b1, 1'b0, 1'b0, 1'b0, '0};
        vecs[3] = '{BLK2, 1'b0, 1'b1, 1'b1, 1'b1, D2};
        vecs[4] = '{ABC,  1'b1, 1'b1, 1'b0, 1'b1, D256};

        // ---- reset ----
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // ---- "abc" on all three UNROLL variants ----
        for (int i = 0; i < 3; i++) dvs[i] = dv_cnt[i];
        exp_q.push_back(D256);
        send(ABC, 1'b1, 1'b1, 1'b0, 3'b111);
        for (int s = 0; s < 3; s++) begin
            check_int("unroll1_round_idx", int'(ridx[0]), s);
            check_int("unroll2_round_idx", int'(ridx[1]), 2 * s);
            check_int("unroll4_round_idx", int'(ridx[2]), 4 * s);
            tick();
        end
        wait_idle("abc_done");
        drain("abc_unroll1_digest");
        check("abc_unroll2_digest", dig[1], D256);
        check("abc_unroll4_digest", dig[2], D256);
        check_int("abc_unroll1_latency", lat[0], 65);
        check_int("abc_unroll2_latency", lat[1], 33);
        check_int("abc_unroll4_latency", lat[2], 17);
        check_int("abc_unroll1_pulses", dv_cnt[0] - dvs[0], 1);
        check_int("abc_unroll2_pulses", dv_cnt[1] - dvs[1], 1);
        check_int("abc_unroll4_pulses", dv_cnt[2] - dvs[2], 1);
        held = D256;

        // ---- table-driven vectors on the UNROLL=1 core ----
        for (int v = 0; v < 5; v++) begin
            acc0 = acc_cnt[0];
            dv0  = dv_cnt[0];
            if (vecs[v].has_dv) begin
                exp_q.push_back(vecs[v].exp);
                held = vecs[v].exp;
            end
            send(vecs[v].blk, vecs[v].first, vecs[v].last, vecs[v].mode, 3'b001);
            wait_idle($sformatf("vec%0d_done", v));
            drain($sformatf("vec%0d_digest", v));
            check($sformatf("vec%0d_digest_hold", v), dig[0], held);
            check_int($sformatf("vec%0d_accepts", v), acc_cnt[0] - acc0, 1);
            check_int($sformatf("vec%0d_pulses", v), dv_cnt[0] - dv0, int'(vecs[v].has_dv));
        end

        // ---- reset in the middle of a block ----
        dv0 = dv_cnt[0];
        send(ABC, 1'b1, 1'b1, 1'b1, 3'b001);
        n = 0;
        while (ridx[0] != 7'd20 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) timeout_fail("midrst_round20");
        check_int("midrst_no_pulse_before", dv_cnt[0] - dv0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (70) tick();
        check_int("midrst_no_pulse_after", dv_cnt[0] - dv0, 0);
        exp_q.push_back(D256);
        send(ABC, 1'b0, 1'b1, 1'b1, 3'b001);
        wait_idle("midrst_abc_done");
        drain("midrst_chain_from_iv256");

        // ---- back-to-back two-block message, inputs churning while busy ----
        acc0  = acc_cnt[0];
        dv0   = dv_cnt[0];
        data  = BLK1;
        first = 1'b1;
        last  = 1'b0;
        mode  = 1'b0;
        vld   = 3'b001;
        tick();
        n = 0;
        while (!rdy[0] && n < 200) begin
            for (int k = 0; k < 16; k++) data[32*k +: 32] = $urandom;
            first = 1'($urandom_range(0, 1));
            last  = 1'($urandom_range(0, 1));
            mode  = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (n >= 200) timeout_fail("b2b_ready");
        check_int("b2b_no_pulse_first_block", int'(dv[0]), 0);
        data  = BLK2;
        first = 1'b0;
        last  = 1'b1;
        mode  = 1'b1;
        exp_q.push_back(D2);
        tick();
        vld = 3'b000;
        wait_idle("b2b_done");
        drain("b2b_digest");
        check_int("b2b_accepts", acc_cnt[0] - acc0, 2);
        check_int("b2b_accept_spacing", acc_t[0] - acc_tp[0], 66);
        check_int("b2b_pulses", dv_cnt[0] - dv0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha2_multiblock_core.md
SHA2_MULTIBLOCK_CORE -- requirements
Module: sha2_multiblock_core

Interface
REQ-001 Parameter UNROLL, default 1, SHA rounds per clock; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 blk_valid  input  1  512-bit padded message block offered.
REQ-005 blk_ready  output  1  core can accept a block.
REQ-006 blk_data  input  512  block, big-endian; W0 = bits 511:480, W15 = bits 31:0.
REQ-007 blk_first  input  1  block starts a new message; chaining state reloads from IV.
REQ-008 blk_last  input  1  block ends the message; a digest is produced.
REQ-009 mode_224  input  1  1 = SHA-224, 0 = SHA-256; sampled only when a blk_first block is accepted.
REQ-010 digest  output  256  final hash, {H0..H7}; in SHA-224 mode, bits 255:32 = H0..H6 and bits 31:0 = 0.
REQ-011 digest_valid  output  1  one-cycle pulse when digest is updated.
REQ-012 busy  output  1  block in progress, equal to !blk_ready.
REQ-013 round_idx  output  7  current round number; 0 in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ROUND and UPDATE; blk_ready = 1 only in IDLE.
REQ-015 Accept SHALL occur on blk_valid && blk_ready. On accept:
- W[0..15] load from blk_data.
- Working vars a..h load from the IV (mode per mode_224) if blk_first = 1, else from H0..H7.
- If blk_first = 1, H0..H7 also load from that IV and the mode register latches mode_224.
- State -> ROUND, round_idx = 0.
REQ-016 In ROUND, each edge SHALL perform UNROLL consecutive FIPS 180-4 compression rounds:
- K constants from an internal 64-entry table.
- Wt for t >= 16 generated on the fly from a 16-word sliding window.
- round_idx += UNROLL.
- The edge that completes round 63 SHALL move the state to UPDATE.
REQ-017 All additions SHALL be modulo 2^32; rotations SHALL be true 32-bit rotates.
REQ-018 UPDATE edge:
- Hi <= Hi + working var i, for each i.
- If the block's latched blk_last = 1, digest <= the new H values, masked per mode, and digest_valid = 1 for exactly that following cycle.
- State -> IDLE.
REQ-019 Latency: with accept at edge E0, ROUND spans edges E1..EN where N = 64/UNROLL, and UPDATE is edge EN+1. digest_valid and blk_ready are high in the cycle after EN+1. The earliest next accept is edge EN+2. Per-block period is N+2 cycles (66, 34 or 18).
REQ-020 blk_data, blk_first, blk_last and mode_224 SHALL be ignored outside the accept cycle.
REQ-021 Chaining:
- A non-first block SHALL chain from the current H, whatever the history.
- A non-first block after reset chains from the SHA-256 IV.
- blk_first && blk_last together SHALL hash a single-block message.
REQ-022 digest SHALL hold its last value until the next digest update or reset; non-last blocks SHALL NOT change digest.
REQ-023 IVs:
- SHA-256: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- SHA-224: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.

Reset
REQ-024 While rst = 1 at an edge:
- State -> IDLE, round_idx = 0, blk_ready = 1, busy = 0.
- digest_valid = 0, digest = 0.
- H0..H7 = SHA-256 IV, mode = SHA-256.
REQ-025 rst SHALL override any simultaneous accept. Reset mid-block SHALL abort the block with no digest_valid pulse; rst has priority over every other update.

Verification
REQ-026 UNROLL=1, single block "abc" (61626380, zeros, final word 00000018), first = last = 1, mode_224 = 0 -> digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; digest_valid exactly 65 cycles after the accept edge.
REQ-027 Same "abc" block with mode_224 = 1 -> digest = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
REQ-028 Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", sent back-to-back with blk_valid held high -> exactly one digest_valid, digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; the second accept occurs 66 cycles after the first.
REQ-029 UNROLL = 2 and UNROLL = 4 rerun REQ-026 -> identical digest; digest_valid after 33 and 17 cycles respectively; round_idx steps by UNROLL.
REQ-030 Reset mid-op:
- Stimulus: assert rst at round_idx = 20 of a first block, then send the "abc" block as a non-first block.
- Required: no digest_valid before rst, and all outputs at REQ-024 values after rst.
- Required: the following block result equals REQ-026, showing H was reset to the SHA-256 IV.
REQ-031 Protocol:
- Stimulus: hold blk_valid = 1 with changing blk_data while busy.
- Required: no extra accepts occur and the result is unaffected; a first/non-last block produces no digest_valid.
